// File: rtl/idex_hazard_stage.sv
// idex_hazard_stage
//
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Each cycle the instruction in ID is captured into the ID/EX slot. The slot
// becomes a bubble on reset, on a taken-branch flush, or on a load-use stall.
// A stall also holds PC and IF/ID for one cycle.
//
// Optional feature: define IDEX_STALL_COUNTER_EN to add out_stall_count, a
// saturating count of load-use stall cycles. Reset clears it. Flush bubbles
// are not counted.
//
// Ports:
//   in_clk, in_rst        clock, synchronous active-high reset
//   in_flush              squash the instruction in ID (taken branch in EX)
//   in_ifid_*             decoded instruction fields from ID
//   out_idex_*            registered ID/EX slot contents for EX
//   out_idex_valid        0 when the slot holds a bubble
//   out_pc_write          PC enable (low = hold)
//   out_ifid_write        IF/ID enable (low = hold)
//   out_stall             combinational load-use stall
//   out_stall_count       stall cycle counter (IDEX_STALL_COUNTER_EN only)

module idex_hazard_stage (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_flush,
    input  logic [6:0]  in_ifid_upcode,
    input  logic [4:0]  in_ifid_rs1,
    input  logic [4:0]  in_ifid_rs2,
    input  logic [4:0]  in_ifid_rd,
    input  logic [31:0] in_ifid_pc,
    input  logic [31:0] in_ifid_rd1,
    input  logic [31:0] in_ifid_rd2,
    input  logic [31:0] in_ifid_imm,
    input  logic        in_ifid_regwrite,
    input  logic        in_ifid_memread,
    input  logic        in_ifid_memwrite,
    input  logic        in_ifid_branch,
    output logic [6:0]  out_idex_upcode,
    output logic [4:0]  out_idex_rs1,
    output logic [4:0]  out_idex_rs2,
    output logic [4:0]  out_idex_rd,
    output logic [31:0] out_idex_pc,
    output logic [31:0] out_idex_rd1,
    output logic [31:0] out_idex_rd2,
    output logic [31:0] out_idex_imm,
    output logic        out_idex_regwrite,
    output logic        out_idex_memread,
    output logic        out_idex_memwrite,
    output logic        out_idex_branch,
    output logic        out_idex_valid,
    output logic        out_pc_write,
    output logic        out_ifid_write,
    output logic        out_stall
`ifdef IDEX_STALL_COUNTER_EN
    ,
    output logic [31:0] out_stall_count
`endif
);

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef struct packed {
        logic [6:0]  upcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        valid;
    } slot_t;

    slot_t slot_q, slot_d, bubble, capture;
    logic  uses_rs1, uses_rs2, hazard, stall;

    // Bubble is an addi x0,x0,0 with all control cleared.
    always_comb begin
        bubble        = '0;
        bubble.upcode = OpImm;
    end

    always_comb begin
        capture          = '0;
        capture.upcode   = in_ifid_upcode;
        capture.rs1      = in_ifid_rs1;
        capture.rs2      = in_ifid_rs2;
        capture.rd       = in_ifid_rd;
        capture.pc       = in_ifid_pc;
        capture.rd1      = in_ifid_rd1;
        capture.rd2      = in_ifid_rd2;
        capture.imm      = in_ifid_imm;
        capture.regwrite = in_ifid_regwrite;
        capture.memread  = in_ifid_memread;
        capture.memwrite = in_ifid_memwrite;
        capture.branch   = in_ifid_branch;
        capture.valid    = 1'b1;
    end

    always_comb begin
        uses_rs1 = !(in_ifid_upcode == OpLui || in_ifid_upcode == OpAuipc ||
                     in_ifid_upcode == OpJal);
        uses_rs2 = (in_ifid_upcode == OpReg || in_ifid_upcode == OpStore ||
                    in_ifid_upcode == OpBr);
        // A store's rs2 match is resolved by the MEM-stage write-data forward.
        hazard = slot_q.memread && (slot_q.rd != 5'd0) &&
                 ((uses_rs1 && (slot_q.rd == in_ifid_rs1)) ||
                  (uses_rs2 && (in_ifid_upcode != OpStore) && (slot_q.rd == in_ifid_rs2)));
        stall  = hazard && !in_flush;
    end

    always_comb begin
        slot_d = capture;
        if (in_flush || stall) begin
            slot_d = bubble;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            slot_q <= bubble;
        end else begin
            slot_q <= slot_d;
        end
    end

`ifdef IDEX_STALL_COUNTER_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign out_stall_count = stall_count_q;
`endif

    assign out_idex_upcode   = slot_q.upcode;
    assign out_idex_rs1      = slot_q.rs1;
    assign out_idex_rs2      = slot_q.rs2;
    assign out_idex_rd       = slot_q.rd;
    assign out_idex_pc       = slot_q.pc;
    assign out_idex_rd1      = slot_q.rd1;
    assign out_idex_rd2      = slot_q.rd2;
    assign out_idex_imm      = slot_q.imm;
    assign out_idex_regwrite = slot_q.regwrite;
    assign out_idex_memread  = slot_q.memread;
    assign out_idex_memwrite = slot_q.memwrite;
    assign out_idex_branch   = slot_q.branch;
    assign out_idex_valid    = slot_q.valid;
    assign out_stall         = stall;
    assign out_pc_write      = ~stall;
    assign out_ifid_write    = ~stall;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed testbench for idex_hazard_stage.
module tb_idex_hazard_stage;

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpLui   = 7'b0110111;

    logic        in_clk = 1'b0;
    logic        in_rst, in_flush;
    logic [6:0]  in_ifid_upcode;
    logic [4:0]  in_ifid_rs1, in_ifid_rs2, in_ifid_rd;
    logic [31:0] in_ifid_pc, in_ifid_rd1, in_ifid_rd2, in_ifid_imm;
    logic        in_ifid_regwrite, in_ifid_memread, in_ifid_memwrite, in_ifid_branch;
    logic [6:0]  out_idex_upcode;
    logic [4:0]  out_idex_rs1, out_idex_rs2, out_idex_rd;
    logic [31:0] out_idex_pc, out_idex_rd1, out_idex_rd2, out_idex_imm;
    logic        out_idex_regwrite, out_idex_memread, out_idex_memwrite, out_idex_branch;
    logic        out_idex_valid, out_pc_write, out_ifid_write, out_stall;
`ifdef IDEX_STALL_COUNTER_EN
    logic [31:0] out_stall_count;
    logic [31:0] saved_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 in_clk = ~in_clk;

    idex_hazard_stage dut (
        .in_clk            (in_clk),
        .in_rst            (in_rst),
        .in_flush          (in_flush),
        .in_ifid_upcode    (in_ifid_upcode),
        .in_ifid_rs1       (in_ifid_rs1),
        .in_ifid_rs2       (in_ifid_rs2),
        .in_ifid_rd        (in_ifid_rd),
        .in_ifid_pc        (in_ifid_pc),
        .in_ifid_rd1       (in_ifid_rd1),
        .in_ifid_rd2       (in_ifid_rd2),
        .in_ifid_imm       (in_ifid_imm),
        .in_ifid_regwrite  (in_ifid_regwrite),
        .in_ifid_memread   (in_ifid_memread),
        .in_ifid_memwrite  (in_ifid_memwrite),
        .in_ifid_branch    (in_ifid_branch),
        .out_idex_upcode   (out_idex_upcode),
        .out_idex_rs1      (out_idex_rs1),
        .out_idex_rs2      (out_idex_rs2),
        .out_idex_rd       (out_idex_rd),
        .out_idex_pc       (out_idex_pc),
        .out_idex_rd1      (out_idex_rd1),
        .out_idex_rd2      (out_idex_rd2),
        .out_idex_imm      (out_idex_imm),
        .out_idex_regwrite (out_idex_regwrite),
        .out_idex_memread  (out_idex_memread),
        .out_idex_memwrite (out_idex_memwrite),
        .out_idex_branch   (out_idex_branch),
        .out_idex_valid    (out_idex_valid),
        .out_pc_write      (out_pc_write),
        .out_ifid_write    (out_ifid_write),
        .out_stall         (out_stall)
`ifdef IDEX_STALL_COUNTER_EN
        ,
        .out_stall_count   (out_stall_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge so registered outputs have settled.
    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                          input logic rw, input logic mr, input logic mw);
        in_ifid_upcode   = op;
        in_ifid_rs1      = rs1;
        in_ifid_rs2      = rs2;
        in_ifid_rd       = rd;
        in_ifid_pc       = pc;
        in_ifid_rd1      = pc ^ 32'hA5A5_0000;
        in_ifid_rd2      = pc ^ 32'h0000_5A5A;
        in_ifid_imm      = imm;
        in_ifid_regwrite = rw;
        in_ifid_memread  = mr;
        in_ifid_memwrite = mw;
        in_ifid_branch   = 1'b0;
        #1;
    endtask

    // Issue lw x<rd>, 0(x1) and clock it into ID/EX.
    task automatic load_into_ex(input logic [4:0] rd, input logic [31:0] pc);
        set_id(OpLoad, 5'd1, 5'd0, rd, pc, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        in_rst   = 1'b1;
        in_flush = 1'b0;
        in_ifid_upcode   = 7'($urandom);
        in_ifid_rs1      = 5'($urandom);
        in_ifid_rs2      = 5'($urandom);
        in_ifid_rd       = 5'($urandom);
        in_ifid_pc       = $urandom;
        in_ifid_rd1      = $urandom;
        in_ifid_rd2      = $urandom;
        in_ifid_imm      = $urandom;
        in_ifid_regwrite = 1'b1;
        in_ifid_memread  = 1'b1;
        in_ifid_memwrite = 1'b1;
        in_ifid_branch   = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(out_idex_valid), 32'd0);
        check("rst_upcode", 32'(out_idex_upcode), 32'(OpImm));
        check("rst_rs1", 32'(out_idex_rs1), 32'd0);
        check("rst_rs2", 32'(out_idex_rs2), 32'd0);
        check("rst_rd", 32'(out_idex_rd), 32'd0);
        check("rst_pc", out_idex_pc, 32'd0);
        check("rst_rd1", out_idex_rd1, 32'd0);
        check("rst_rd2", out_idex_rd2, 32'd0);
        check("rst_imm", out_idex_imm, 32'd0);
        check("rst_ctrl", {28'd0, out_idex_regwrite, out_idex_memread, out_idex_memwrite,
                           out_idex_branch}, 32'd0);
        check("rst_stall", 32'(out_stall), 32'd0);
        check("rst_pc_write", 32'(out_pc_write), 32'd1);
        check("rst_ifid_write", 32'(out_ifid_write), 32'd1);
`ifdef IDEX_STALL_COUNTER_EN
        check("rst_count", out_stall_count, 32'd0);
`endif
        in_rst = 1'b0;

        // Load-use: lw x5,0(x1); add x6,x5,x2
        set_id(OpLoad, 5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 1'b1, 1'b1, 1'b0);
        check("lu_no_stall_before", 32'(out_stall), 32'd0);
        tick();
        check("lu_lw_valid", 32'(out_idex_valid), 32'd1);
        check("lu_lw_rd", 32'(out_idex_rd), 32'd5);
        check("lu_lw_memread", 32'(out_idex_memread), 32'd1);
        check("lu_lw_pc", out_idex_pc, 32'h100);
        check("lu_lw_rd1", out_idex_rd1, 32'hA5A5_0100);
        set_id(OpReg, 5'd5, 5'd2, 5'd6, 32'h104, 32'd0, 1'b1, 1'b0, 1'b0);
        check("lu_stall", 32'(out_stall), 32'd1);
        check("lu_pc_write", 32'(out_pc_write), 32'd0);
        check("lu_ifid_write", 32'(out_ifid_write), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(out_idex_valid), 32'd0);
        check("lu_bubble_rd", 32'(out_idex_rd), 32'd0);
        check("lu_bubble_upcode", 32'(out_idex_upcode), 32'(OpImm));
        check("lu_bubble_regwrite", 32'(out_idex_regwrite), 32'd0);
        check("lu_stall_cleared", 32'(out_stall), 32'd0);
        tick();
        check("lu_add_valid", 32'(out_idex_valid), 32'd1);
        check("lu_add_rs1", 32'(out_idex_rs1), 32'd5);
        check("lu_add_rd", 32'(out_idex_rd), 32'd6);
        check("lu_add_pc", out_idex_pc, 32'h104);

        // Store exemption: sw x5,4(x2) after lw x5
        load_into_ex(5'd5, 32'h200);
        set_id(OpStore, 5'd2, 5'd5, 5'd0, 32'h204, 32'd4, 1'b0, 1'b0, 1'b1);
        check("st_rs2_no_stall", 32'(out_stall), 32'd0);
        check("st_rs2_pc_write", 32'(out_pc_write), 32'd1);
        tick();
        check("st_rs2_valid", 32'(out_idex_valid), 32'd1);
        check("st_rs2_upcode", 32'(out_idex_upcode), 32'(OpStore));
        check("st_rs2_memwrite", 32'(out_idex_memwrite), 32'd1);
        check("st_rs2_imm", out_idex_imm, 32'd4);

        // sw x7,0(x5): base address depends on the load
        load_into_ex(5'd5, 32'h300);
        set_id(OpStore, 5'd5, 5'd7, 5'd0, 32'h304, 32'd0, 1'b0, 1'b0, 1'b1);
        check("st_rs1_stall", 32'(out_stall), 32'd1);
        tick();
        check("st_rs1_bubble", 32'(out_idex_valid), 32'd0);
        tick();
        check("st_rs1_valid", 32'(out_idex_valid), 32'd1);
        check("st_rs1_rs1", 32'(out_idex_rs1), 32'd5);

        // lw x0 then add x3,x0,x0
        load_into_ex(5'd0, 32'h400);
        set_id(OpReg, 5'd0, 5'd0, 5'd3, 32'h404, 32'd0, 1'b1, 1'b0, 1'b0);
        check("x0_no_stall", 32'(out_stall), 32'd0);
        tick();
        check("x0_add_rd", 32'(out_idex_rd), 32'd3);

        // lw x5 then lui x5,1 (source fields hold stale 5s)
        load_into_ex(5'd5, 32'h500);
        set_id(OpLui, 5'd5, 5'd5, 5'd5, 32'h504, 32'h1000, 1'b1, 1'b0, 1'b0);
        check("lui_no_stall", 32'(out_stall), 32'd0);
        tick();
        check("lui_upcode", 32'(out_idex_upcode), 32'(OpLui));
        check("lui_imm", out_idex_imm, 32'h1000);

        // Dependent back-to-back loads: lw x5; lw x6,0(x5)
        load_into_ex(5'd5, 32'h600);
        set_id(OpLoad, 5'd5, 5'd0, 5'd6, 32'h604, 32'd0, 1'b1, 1'b1, 1'b0);
        check("ll_stall", 32'(out_stall), 32'd1);
        tick();
        check("ll_bubble", 32'(out_idex_valid), 32'd0);
        check("ll_no_second_stall", 32'(out_stall), 32'd0);
        tick();
        check("ll_lw2_rd", 32'(out_idex_rd), 32'd6);
        check("ll_lw2_memread", 32'(out_idex_memread), 32'd1);

        // Flush beats stall: lw x5 in EX, add x6,x5 in ID, flush
        set_id(OpImm, 5'd0, 5'd0, 5'd0, 32'h700, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        load_into_ex(5'd5, 32'h704);
`ifdef IDEX_STALL_COUNTER_EN
        saved_count = out_stall_count;
`endif
        set_id(OpReg, 5'd5, 5'd2, 5'd6, 32'h708, 32'd0, 1'b1, 1'b0, 1'b0);
        in_flush = 1'b1;
        #1;
        check("fl_stall", 32'(out_stall), 32'd0);
        check("fl_pc_write", 32'(out_pc_write), 32'd1);
        tick();
        in_flush = 1'b0;
        check("fl_bubble_valid", 32'(out_idex_valid), 32'd0);
        check("fl_bubble_rd", 32'(out_idex_rd), 32'd0);
`ifdef IDEX_STALL_COUNTER_EN
        check("fl_count_unchanged", out_stall_count, saved_count);
`endif

        // Reset mid-stall
        load_into_ex(5'd5, 32'h800);
        set_id(OpReg, 5'd5, 5'd2, 5'd6, 32'h804, 32'd0, 1'b1, 1'b0, 1'b0);
        check("rs_stall", 32'(out_stall), 32'd1);
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        #1;
        check("rs_bubble", 32'(out_idex_valid), 32'd0);
        check("rs_no_stall", 32'(out_stall), 32'd0);
        tick();
        check("rs_add_captured", 32'(out_idex_rd), 32'd6);

`ifdef IDEX_STALL_COUNTER_EN
        // Counter: three separate load-use pairs, then reset clears it
        check("cnt_after_reset", out_stall_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            load_into_ex(5'd9, 32'h900 + 32'(i * 16));
            set_id(OpReg, 5'd1, 5'd9, 5'd10, 32'h904 + 32'(i * 16), 32'd0, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
        end
        check("cnt_three", out_stall_count, 32'd3);
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        check("cnt_cleared", out_stall_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idex_hazard_stage.md
# idex_hazard_stage

ID/EX pipeline register with integrated load-use hazard detection and branch-flush bubble insertion for the five-stage RISC-V core. It sits between decode and execute. It captures the decoded instruction each cycle and supplies the registered rs1/rs2/rd/opcode and control bits that the EX-stage forwarding logic consumes. It stalls PC and IF/ID when a load result cannot be forwarded in time, and it turns the ID/EX slot into a NOP on stall or on a taken-branch flush.

## Interface
- No parameters; datapath width is fixed at 32, register index width at 5.
- in_clk  input  1  core clock; all state updates on rising edge
- in_rst  input  1  synchronous, active-high reset
- in_flush  input  1  taken branch/jump resolved in EX; squash the instruction in ID
- in_ifid_upcode  input  7  opcode of the instruction in ID
- in_ifid_rs1, in_ifid_rs2, in_ifid_rd  input  5 each  register indices from ID
- in_ifid_pc, in_ifid_rd1, in_ifid_rd2, in_ifid_imm  input  32 each  PC, register-file read data, immediate
- in_ifid_regwrite, in_ifid_memread, in_ifid_memwrite, in_ifid_branch  input  1 each  decoded control
- out_idex_upcode  output  7  registered opcode
- out_idex_rs1, out_idex_rs2, out_idex_rd  output  5 each  registered indices
- out_idex_pc, out_idex_rd1, out_idex_rd2, out_idex_imm  output  32 each  registered data
- out_idex_regwrite, out_idex_memread, out_idex_memwrite, out_idex_branch  output  1 each  registered control
- out_idex_valid  output  1  0 when the slot holds a bubble
- out_pc_write, out_ifid_write  output  1 each  enables for PC and IF/ID; low = hold
- out_stall  output  1  load-use stall this cycle (combinational)

## Operation
- uses_rs2 = ID opcode in {0110011 R, 0100011 S, 1100011 B}. Opcodes 0010011, 0000011 and 1100111 use rs1 only. 0110111, 0010111 and 1101111 use neither source.
- uses_rs1 = every opcode except 0110111, 0010111 and 1101111.
- Load-use hazard requires all of: out_idex_memread=1, out_idex_rd≠0, and at least one of:
  - uses_rs1 and out_idex_rd==in_ifid_rs1;
  - uses_rs2, ID opcode≠0100011, and out_idex_rd==in_ifid_rs2.
- A store whose only match is on rs2 does not stall. The load data reaches the store's write-data path through the MEM-stage write-data forward.
- out_stall = hazard & ~in_flush. out_pc_write = out_ifid_write = ~out_stall.
- Next slot per cycle, in priority order:
  - in_rst: bubble.
  - in_flush: bubble.
  - out_stall: bubble.
  - Otherwise: capture all in_ifid_* fields and set valid=1.
- Bubble contents: regwrite, memread, memwrite and branch all 0; valid=0; rd, rs1 and rs2 = 0; upcode=7'b0010011; pc, rd1, rd2 and imm = 0.
- A bubble has rd=0 and regwrite=0, so it never matches any downstream forwarding or hazard compare.

## Timing
- Reset: every registered output is 0 except out_idex_upcode=7'b0010011. The combinational outputs therefore read out_stall=0 and out_pc_write=out_ifid_write=1.
- Register latency: 1 cycle from ID inputs to the out_idex_* outputs.
- Stall detection is combinational from out_idex_* and in_ifid_* in the same cycle. Exactly one bubble is inserted per load-use. In the next cycle the load has left ID/EX, so the hazard clears unless a new load-use pair forms.
- Flush and stall in the same cycle: the flush wins. out_stall=0 so PC/IF-ID advance to the redirect target, and the slot becomes a bubble.
- Reset asserted mid-stall: the slot becomes a bubble on that edge. The next cycle sees out_idex_memread=0, so no stall.
- Back-to-back loads where the second load depends on the first: a single stall, then normal flow.

## Configuration
- IDEX_STALL_COUNTER_EN defined: adds output out_stall_count [31:0].
  - Increments on every rising edge with out_stall=1 and in_rst=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared to 0 by in_rst.
  - Flush-induced bubbles are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold in_rst 2 cycles with random in_ifid_* -> out_idex_valid=0, out_idex_upcode=0010011, all other out_idex_* = 0, out_pc_write=1.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x2` -> the cycle with lw in ID/EX and add in ID gives out_stall=1 and out_pc_write=0. Next edge gives a bubble (valid=0, rd=0). The following edge captures add with rs1=5.
- Store exemption: `lw x5` then `sw x5,4(x2)` (rs2=5, rs1=2) -> out_stall=0 and sw captured directly. Same pair with `sw x7,0(x5)` (rs1=5) -> out_stall=1.
- x0 / no-use: `lw x0` followed by `add x3,x0,x0` -> no stall. `lw x5` followed by `lui x5,1` -> no stall.
- Flush priority: load-use condition present and in_flush=1 -> out_stall=0, out_pc_write=1, next out_idex_valid=0. With IDEX_STALL_COUNTER_EN the count is unchanged.
- Counter: with IDEX_STALL_COUNTER_EN, 3 separate load-use pairs -> out_stall_count=3. Then in_rst for 1 cycle -> 0.
